fc_mac_engine: RTL
==================

FC_MAC_ENGINE -- requirements
Module: fc_mac_engine

Interface
REQ-001 SHALL have parameter N_IN, default 9: activations per input vector.
REQ-002 SHALL have parameter N_OUT, default 4: output neurons.
REQ-003 SHALL have parameter DW, default 8: signed activation, weight and bias width.
REQ-004 SHALL have parameter ACC_W, default 24: signed accumulator width; legal only if ACC_W >= 2*DW + clog2(N_IN) + 1.
REQ-005 SHALL have parameter OUT_W, default 16: signed result width.
REQ-006 SHALL have parameter RELU_EN, default 0: 1 applies ReLU after saturation.
REQ-007 SHALL have port clk, input, 1: clock; all logic rising-edge.
REQ-008 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-009 SHALL have port start, input, 1: begin one inference.
REQ-010 SHALL have port in_valid, input, 1 and in_data, input, DW: activation stream.
REQ-011 SHALL have port in_ready, output, 1: activation accepted when in_valid & in_ready.
REQ-012 SHALL have ports w_we, input, 1; w_addr, input, clog2(N_IN*N_OUT); w_data, input, DW: weight write, address = j*N_IN + i.
REQ-013 SHALL have ports b_we, input, 1; b_addr, input, clog2(N_OUT); b_data, input, DW: bias write.
REQ-014 SHALL have ports out_valid, output, 1; out_ready, input, 1; out_data, output, OUT_W; out_idx, output, clog2(N_OUT): result stream.
REQ-015 SHALL have ports busy, output, 1 (high when not IDLE) and done, output, 1 (one-cycle pulse).

Function
REQ-016 FSM states SHALL be IDLE, LOAD, MAC, BIAS, OUT, FIN.
REQ-017 IDLE: start=1 -> LOAD; start SHALL be ignored in any other state.
REQ-018 LOAD: in_ready=1; activations stored to x[0..N_IN-1] in arrival order; after N_IN handshakes -> MAC with j=0; in_ready=0 in all other states.
REQ-019 MAC: acc cleared on entry, then exactly N_IN cycles of acc += x[i]*W[j][i], i=0..N_IN-1, full-precision signed product, sign-extended to ACC_W.
REQ-020 BIAS: one cycle, acc += sign-extended bias[j] -> OUT.
REQ-021 OUT: out_data = clamp(acc, -2^(OUT_W-1), 2^(OUT_W-1)-1); if RELU_EN=1, negative results -> 0; out_idx = j; out_valid=1.
REQ-022 out_data, out_idx SHALL be stable while out_valid & !out_ready.
REQ-023 On out_valid & out_ready: j<N_OUT-1 -> MAC with j+1; j=N_OUT-1 -> FIN.
REQ-024 FIN: done=1 for exactly one cycle -> IDLE.
REQ-025 First out_valid SHALL rise N_IN+2 cycles after the edge accepting the last activation; subsequent results N_IN+2 cycles after each output handshake.
REQ-026 Weight/bias writes SHALL take effect only when busy=0; writes while busy=1 SHALL be dropped.
REQ-027 Weight and bias storage SHALL NOT be cleared by rst; contents persist across inferences.
REQ-028 Activation buffer SHALL be overwritten each inference; no accumulation across inferences.

Reset
REQ-029 While rst=1: state IDLE; in_ready=0, out_valid=0, out_data=0, out_idx=0, busy=0, done=0; acc, i, j cleared.
REQ-030 rst asserted in any state SHALL abort the inference at the next edge; no partial result, no done pulse.
REQ-031 rst SHALL take priority over start, in_valid, w_we, b_we in the same cycle.

Verification
REQ-032 Defaults, all W=1, bias=0, x=1..9 -> four results out_data=45, out_idx 0..3, done one cycle after the fourth handshake.
REQ-033 x=127, all W=127, bias=127 -> 145288 saturates to 32767; x=-128, W=127, bias=0 -> -146304 saturates to -32768 (RELU_EN=0) or 0 (RELU_EN=1).
REQ-034 out_ready held low 5 cycles with out_valid=1 -> out_data/out_idx unchanged; next MAC starts only after the handshake; timing per REQ-025.
REQ-035 rst pulsed in MAC for j=2 -> next cycle busy=0, out_valid=0, no done; new start with same x reproduces the REQ-032 results (weights retained).
REQ-036 start and w_we (W[0][0]=5) asserted during MAC -> both ignored; results equal the unmodified run; same write after done -> next inference uses W[0][0]=5.
REQ-037 in_valid gapped (toggled every other cycle) during LOAD -> exactly N_IN values captured in order; results match the gap-free run.

Source files
------------

// File: rtl/fc_mac_engine.sv
`default_nettype none
// ============================================================================
// Module   : fc_mac_engine
// Brief    : Sequential fully-connected layer. Streams N_IN activations, then
//            emits N_OUT saturated (optionally ReLU'd) dot-products plus bias.
// Revision : 1.0
// ============================================================================
module fc_mac_engine #(
  parameter int N_IN    = 9,
  parameter int N_OUT   = 4,
  parameter int DW      = 8,
  parameter int ACC_W   = 24,
  parameter int OUT_W   = 16,
  parameter int RELU_EN = 0,
  localparam int WAW    = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1,
  localparam int BAW    = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_data,
  output logic             in_ready,
  input  logic             w_we,
  input  logic [WAW-1:0]   w_addr,
  input  logic [DW-1:0]    w_data,
  input  logic             b_we,
  input  logic [BAW-1:0]   b_addr,
  input  logic [DW-1:0]    b_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [BAW-1:0]   out_idx,
  output logic             busy,
  output logic             done
);

  localparam int XW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [XW-1:0]  I_LAST = XW'(N_IN - 1);
  localparam logic [BAW-1:0] J_LAST = BAW'(N_OUT - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_MAC  = 3'd2,
    S_BIAS = 3'd3,
    S_OUT  = 3'd4,
    S_FIN  = 3'd5
  } state_t;

  state_t state_q, state_d;

  // Parameter storage is deliberately outside the reset domain.
  logic signed [DW-1:0] x_q     [N_IN];
  logic signed [DW-1:0] w_mem_q [N_IN * N_OUT];
  logic signed [DW-1:0] b_mem_q [N_OUT];

  logic [XW-1:0]           i_q;
  logic [BAW-1:0]          j_q;
  logic                    clr_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [OUT_W-1:0]        out_data_q;

  logic [WAW-1:0]          w_rd_addr;
  logic signed [DW-1:0]    w_x_rd;
  logic signed [DW-1:0]    w_w_rd;
  logic signed [DW-1:0]    w_b_rd;
  logic signed [2*DW-1:0]  w_prod;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [ACC_W-1:0] w_bias_ext;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W-1:0] w_sat;
  logic [OUT_W-1:0]        w_clamped;
  logic [OUT_W-1:0]        w_res;

  // Weight layout is row-major per output neuron: addr = j*N_IN + i.
  assign w_rd_addr  = WAW'(j_q) * WAW'(N_IN) + WAW'(i_q);
  assign w_x_rd     = x_q[i_q];
  assign w_w_rd     = w_mem_q[w_rd_addr];
  assign w_b_rd     = b_mem_q[j_q];
  assign w_prod     = (2*DW)'(w_x_rd) * (2*DW)'(w_w_rd);
  assign w_prod_ext = {{(ACC_W - 2*DW){w_prod[2*DW-1]}}, w_prod};
  assign w_bias_ext = {{(ACC_W - DW){w_b_rd[DW-1]}}, w_b_rd};
  assign w_sum      = acc_q + w_bias_ext;

  always_comb begin
    w_sat = w_sum;
    if (w_sum > SAT_MAX) begin
      w_sat = SAT_MAX;
    end else if (w_sum < SAT_MIN) begin
      w_sat = SAT_MIN;
    end
  end

  assign w_clamped = w_sat[OUT_W-1:0];

  generate
    if (RELU_EN != 0) begin : g_relu
      assign w_res = w_clamped[OUT_W-1] ? '0 : w_clamped;
    end else begin : g_no_relu
      assign w_res = w_clamped;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_LOAD;
      S_LOAD: if (in_valid && (i_q == I_LAST)) state_d = S_MAC;
      S_MAC:  if (!clr_q && (i_q == I_LAST)) state_d = S_BIAS;
      S_BIAS: state_d = S_OUT;
      S_OUT: begin
        if (out_ready) begin
          state_d = (j_q == J_LAST) ? S_FIN : S_MAC;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && (state_q == S_LOAD) && in_valid) begin
      x_q[i_q] <= in_data;
    end
    if (!rst && (state_q == S_IDLE) && w_we) begin
      w_mem_q[w_addr] <= w_data;
    end
    if (!rst && (state_q == S_IDLE) && b_we) begin
      b_mem_q[b_addr] <= b_data;
    end
  end

  // clr_q marks the first MAC cycle of each neuron, which zeroes the accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_q        <= '0;
      j_q        <= '0;
      clr_q      <= 1'b0;
      acc_q      <= '0;
      out_data_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          i_q <= '0;
          j_q <= '0;
        end
        S_LOAD: begin
          if (in_valid) begin
            if (i_q == I_LAST) begin
              i_q   <= '0;
              clr_q <= 1'b1;
            end else begin
              i_q <= i_q + XW'(1);
            end
          end
        end
        S_MAC: begin
          if (clr_q) begin
            acc_q <= '0;
            clr_q <= 1'b0;
          end else begin
            acc_q <= acc_q + w_prod_ext;
            i_q   <= (i_q == I_LAST) ? '0 : i_q + XW'(1);
          end
        end
        S_BIAS: begin
          acc_q      <= w_sum;
          out_data_q <= w_res;
        end
        S_OUT: begin
          if (out_ready && (j_q != J_LAST)) begin
            j_q   <= j_q + BAW'(1);
            clr_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q != S_IDLE) && !rst;
  assign in_ready  = (state_q == S_LOAD) && !rst;
  assign out_valid = (state_q == S_OUT) && !rst;
  assign done      = (state_q == S_FIN) && !rst;
  assign out_data  = rst ? '0 : out_data_q;
  assign out_idx   = rst ? '0 : j_q;

endmodule
`default_nettype wire
